// File: rtl/pipelined_addsub.sv
// Two-stage carry-select add/subtract unit with valid/ready on both sides.
// Stage 1 forms the low sum and both high candidates; stage 2 selects and flags.
module pipelined_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int H = WIDTH / 2;

  logic         s1_valid;
  logic [H:0]   s1_lo;
  logic [H:0]   s1_hi0;
  logic [H:0]   s1_hi1;
  logic         s1_sa;
  logic         s1_sb;
  logic         s1_sub;

  logic             s2_adv;
  logic [WIDTH-1:0] bx;
  logic             c0;
  logic [H:0]       lo;
  logic [H:0]       hi0;
  logic [H:0]       hi1;

  logic [H:0]       hi_sel;
  logic [WIDTH-1:0] sum;
  logic             n_cout;
  logic             n_ovf;
  logic             n_zero;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // Subtract is a + ~b + ~cin; the adder carry is inverted into a borrow later.
  assign bx  = sub ? ~b : b;
  assign c0  = cin ^ sub;
  assign lo  = {1'b0, a[H-1:0]} + {1'b0, bx[H-1:0]}
             + {{H{1'b0}}, c0};
  assign hi0 = {1'b0, a[WIDTH-1:H]} + {1'b0, bx[WIDTH-1:H]};
  assign hi1 = {1'b0, a[WIDTH-1:H]} + {1'b0, bx[WIDTH-1:H]}
             + {{H{1'b0}}, 1'b1};

  assign hi_sel = s1_lo[H] ? s1_hi1 : s1_hi0;
  assign sum    = {hi_sel[H-1:0], s1_lo[H-1:0]};
  assign n_cout = hi_sel[H] ^ s1_sub;
  assign n_ovf  = (s1_sa == s1_sb) && (sum[WIDTH-1] != s1_sa);
  assign n_zero = (sum == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_hi0   <= '0;
      s1_hi1   <= '0;
      s1_sa    <= 1'b0;
      s1_sb    <= 1'b0;
      s1_sub   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lo  <= lo;
        s1_hi0 <= hi0;
        s1_hi1 <= hi1;
        s1_sa  <= a[WIDTH-1];
        s1_sb  <= bx[WIDTH-1];
        s1_sub <= sub;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        s    <= sum;
        cout <= n_cout;
        ovf  <= n_ovf;
        zero <= n_zero;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed corners, backpressure, reset mid-stall
// and a randomized-ready sweep against an arithmetic reference model.
module tb_pipelined_addsub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
  logic        ovf;
  logic        zero;

  int checks;
  int errors;
  bit acc;
  bit drn;
  logic [18:0] q[$];

  pipelined_addsub #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  // Returns {cout, ovf, zero, s}.
  function automatic logic [18:0] ref_model(
    logic [15:0] x, logic [15:0] y, logic ci, logic sb);
    int ux;
    int uy;
    int r;
    logic [15:0] rs;
    logic co;
    logic ov;
    ux = int'(x);
    uy = int'(y);
    if (!sb) begin
      r  = ux + uy + int'(ci);
      co = (r > 65535);
    end else begin
      r  = ux - uy - int'(ci);
      co = (ux < uy + int'(ci));
    end
    rs = r[15:0];
    if (sb) ov = (x[15] != y[15]) && (rs[15] != x[15]);
    else    ov = (x[15] == y[15]) && (rs[15] != x[15]);
    return {co, ov, (rs == 16'h0), rs};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with inputs driven; leaves at the next negedge.
  task automatic cycle();
    logic [18:0] e;
    #1;
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn) begin
      chk("sb_empty_on_drain", 32'(q.size() == 0), 0);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb.s", 32'(s), 32'(e[15:0]));
        chk("sb.cout", 32'(cout), 32'(e[18]));
        chk("sb.ovf", 32'(ovf), 32'(e[17]));
        chk("sb.zero", 32'(zero), 32'(e[16]));
      end
    end
    if (acc) q.push_back(ref_model(a, b, cin, sub));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_one(string tag, logic [15:0] x, logic [15:0] y,
    logic ci, logic sb, logic [15:0] es, logic ec, logic eo);
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    #1 chk({tag, ".in_ready"}, 32'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    #1 chk({tag, ".lat1"}, 32'(out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({tag, ".lat2"}, 32'(out_valid), 1);
    chk({tag, ".s"}, 32'(s), 32'(es));
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
    chk({tag, ".zero"}, 32'(zero), 32'(es == 16'h0));
  endtask

  initial begin
    logic [15:0] bpa[5];
    logic [15:0] bpb[5];
    logic [15:0] iv[8];
    int idx;
    int n;
    int nd;
    checks = 0; errors = 0;
    clk = 0; rst_n = 0; in_valid = 0; out_ready = 1;
    a = 0; b = 0; cin = 0; sub = 0;
    iv = '{16'h0, 16'h1, 16'h2, 16'h7F, 16'hFF,
           16'h7FFF, 16'h8000, 16'hFFFF};

    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.s", 32'(s), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst.in_ready", 32'(in_ready), 1);
    chk("rst.zero", 32'(zero), 0);
    @(negedge clk);

    send_one("add0", 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0);
    send_one("addff", 16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0);
    send_one("addbf", 16'hBFFF, 16'hBFFF, 0, 0, 16'h7FFE, 1, 1);
    send_one("sub53", 16'h0005, 16'h0003, 0, 1, 16'h0002, 0, 0);
    send_one("sub01", 16'h0000, 16'h0001, 0, 1, 16'hFFFF, 1, 0);
    send_one("sub80", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 0, 1);
    send_one("subz", 16'h0001, 16'h0000, 1, 1, 16'h0000, 0, 0);
    send_one("segadd", 16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0);
    send_one("segsub", 16'h0100, 16'h0001, 0, 1, 16'h00FF, 0, 0);
    @(posedge clk);
    @(negedge clk);

    // Backpressure: 5 beats offered against a stalled sink.
    for (int k = 0; k < 5; k++) begin
      bpa[k] = 16'($urandom);
      bpb[k] = 16'($urandom);
    end
    out_ready = 0;
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1; a = bpa[idx]; b = bpb[idx];
      cin = idx[0]; sub = idx[1];
      cycle();
      if (acc) idx++;
    end
    #1;
    chk("bp.accepted", 32'(idx), 2);
    chk("bp.in_ready", 32'(in_ready), 0);
    for (int k = 0; k < 3; k++) begin
      a = 16'($urandom); b = 16'($urandom);
      #1;
      chk("bp.hold_valid", 32'(out_valid), 1);
      chk("bp.hold_s", 32'(s), 32'(q[0][15:0]));
      chk("bp.hold_cout", 32'(cout), 32'(q[0][18]));
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1;
    n = 0; nd = 0;
    while ((idx < 5 || q.size() > 0) && n < 20) begin
      if (idx < 5) begin
        in_valid = 1; a = bpa[idx]; b = bpb[idx];
        cin = idx[0]; sub = idx[1];
      end else in_valid = 0;
      cycle();
      if (acc) idx++;
      if (drn) nd++;
      n++;
    end
    chk("bp.drained", 32'(nd), 5);
    chk("bp.sb_empty", 32'(q.size()), 0);

    // Reset while full and stalled.
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; a = 16'($urandom); b = 16'($urandom);
      cycle();
    end
    #2 rst_n = 0;
    #1;
    chk("rstmid.out_valid", 32'(out_valid), 0);
    chk("rstmid.s", 32'(s), 0);
    chk("rstmid.cout", 32'(cout), 0);
    q.delete();
    in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    #1 chk("rstmid.in_ready", 32'(in_ready), 1);
    send_one("post_rst", 16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0);
    @(posedge clk);
    @(negedge clk);

    // Sweep with random sink readiness.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        for (int c = 0; c < 2; c++)
          for (int m = 0; m < 2; m++) begin
            a = iv[i] + iv[j];
            b = 16'(iv[i] * iv[j]);
            cin = c[0]; sub = m[0]; in_valid = 1;
            acc = 0; n = 0;
            while (!acc && n < 50) begin
              out_ready = ($urandom_range(0, 3) != 0);
              cycle();
              n++;
            end
            chk("rnd.accept", 32'(acc), 1);
          end
    in_valid = 0; out_ready = 1; n = 0;
    while (q.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("rnd.flush", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Two-stage pipelined add/subtract unit built on the carry-select scheme, with a valid/ready handshake on both sides.
- It complements the combinational adders: it supplies subtraction with borrow (the inverse operation) and registers the carry-select split across a pipeline boundary.
- It sits between an operand source and a result sink. The sink may apply backpressure.

Parameters:
- WIDTH, 16, operand/result width. Must be even and ≥4. The low segment is WIDTH/2 bits; the high segment is WIDTH/2 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit accepts beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result this cycle
- s  output  WIDTH  result
- cout  output  1  carry-out (add) / borrow-out (sub)
- ovf  output  1  signed two's-complement overflow
- zero  output  1  s == 0

Behaviour:
- Arithmetic, add (sub=0): {cout,s} = a + b + cin, exact (WIDTH+1)-bit result.
- Arithmetic, sub (sub=1):
  - s = (a − b − cin) mod 2^WIDTH.
  - cout = 1 iff a < b + cin (unsigned borrow).
  - Internally: a + ~b + ~cin, with cout being the inverted adder carry.
- ovf:
  - add: operands have equal sign and result sign differs.
  - sub: a and b have opposite signs and result sign differs from a.
- Stage 1, on accept:
  - Registers the low-segment sum and its carry.
  - Registers both high-segment candidates: high(a) + high(b') + 0 and high(a) + high(b') + 1, each WIDTH/2+1 bits.
  - Registers the sign bits and sub.
- Stage 2: selects the high candidate using the registered low carry, applies the borrow inversion for sub, and registers s, cout, ovf and zero.
- Latency: result is presented exactly 2 cycles after acceptance when there is no backpressure. Throughput is 1 beat/cycle.
- Handshake:
  - A beat transfers on a side when valid && ready on that side.
  - Outputs hold stable while out_valid && !out_ready.
  - A stage advances when its successor is empty or draining this cycle.
  - in_ready = !s1_valid || s1 advances; it depends only on out_ready and internal state.
  - in_valid and operands may change freely while in_ready = 0 (no beat is taken).
- Full pipeline with out_ready=0: in_ready=0 and both stages hold. When out_ready rises, one beat drains per cycle and no beat is lost or duplicated.
- Simultaneous accept and drain in the same cycle: both occur and occupancy is unchanged.
- Reset, asserted at any time, including mid-stall:
  - Immediately clears s1_valid and out_valid.
  - Clears s, cout, ovf and zero to 0.
  - in_ready = 1 after reset deasserts.
  - In-flight beats are discarded.
- Reset deassertion is synchronised by the integrator; the block only requires that rst_n be low for ≥1 clk edge.
- Wrap-around (e.g. FFFF+1) is legal arithmetic, not an error; only cout/ovf report it.

Test Plan:
- Add corners, WIDTH=16, out_ready=1:
  - 0+0+0 → s=0000, cout=0, zero=1.
  - FFFF+FFFF+1 → s=FFFF, cout=1.
  - BFFF+BFFF+0 → s=7FFE, cout=1, ovf=1.
  - Each result appears 2 cycles after accept.
- Sub corners:
  - 0005−0003−0 → 0002, cout=0.
  - 0000−0001−0 → FFFF, cout=1.
  - 8000−0001−0 → 7FFF, ovf=1.
  - 0001−0000−1 → 0000, zero=1, cout=0.
- Carry across segment boundary: 00FF+0001+0 → 0100. With sub=1, 0100−0001 → 00FF. This confirms the high candidate is selected by the low carry.
- Backpressure:
  - Stream 5 beats with out_ready=0 → accepts exactly 2 beats, then in_ready=0, outputs stable.
  - Release out_ready → remaining beats emerge in order, one per cycle, and the scoreboard matches.
- Reset mid-stall: pipeline full, pull rst_n low between edges → out_valid=0 and s=0 immediately. After release, in_ready=1 and the next result is correct.
- Random sweep: same loops as the adder bench (a=i+j, b=i·j, cin and sub both values) with random out_ready. Compare against a reference model including cout/ovf/zero. Zero mismatches required.
